// File: rtl/ul_pack_pkg.sv
// Shared types and constants for the uplink IQ-to-Ethernet packer.
package ul_pack_pkg;

    typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

    localparam int HDR_WORDS = 3;

    // Bit offsets of header fields inside words 1 and 2
    localparam int HDR1_SRC_LSB   = 32;
    localparam int HDR1_ETH_LSB   = 16;
    localparam int HDR1_ANTE_LSB  = 0;
    localparam int HDR2_FRAME_LSB = 48;
    localparam int HDR2_SLOT_LSB  = 40;
    localparam int HDR2_SYM_LSB   = 32;

    function automatic int BIT_WIDTH(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ul_pack_hdr_gen.sv
// Combinational mux selecting one of the three Ethernet/eCPRI-style header words.
module ul_pack_hdr_gen
    import ul_pack_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0000_0000_0001,
    parameter logic [15:0] ETH_TYPE = 16'hAEFE
) (
    input  logic [1:0]  idx_i,
    input  logic [2:0]  ante_i,
    input  logic [15:0] frame_i,
    input  logic [7:0]  slot_i,
    input  logic [7:0]  symbol_i,
    output logic [63:0] word_o
);

    always_comb begin
        word_o = '0;
        case (idx_i)
            2'd0: word_o = {DST_MAC, SRC_MAC[47:32]};
            2'd1: begin
                word_o[HDR1_SRC_LSB +: 32] = SRC_MAC[31:0];
                word_o[HDR1_ETH_LSB +: 16] = ETH_TYPE;
                word_o[HDR1_ANTE_LSB +: 3] = ante_i;
            end
            2'd2: begin
                word_o[HDR2_FRAME_LSB +: 16] = frame_i;
                word_o[HDR2_SLOT_LSB +: 8]   = slot_i;
                word_o[HDR2_SYM_LSB +: 8]    = symbol_i;
            end
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/ul_pack.sv
// Packs one antenna symbol of IQ words into one Ethernet frame for an Avalon-ST MAC.
// Optional statistics counters are enabled with the UL_PACK_STATS_EN macro.
module ul_pack
    import ul_pack_pkg::*;
#(
    parameter int          SCS_NUM  = 3276,
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0000_0000_0001,
    parameter logic [15:0] ETH_TYPE = 16'hAEFE
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [63:0] din_data,
    input  logic [2:0]  din_ante,
    input  logic [15:0] din_frame,
    input  logic [7:0]  din_slot,
    input  logic [7:0]  din_symbol,
    output logic        din_ready,
    output logic [63:0] dout_data,
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [2:0]  dout_empty,
    output logic        dout_error,
    input  logic        dout_ready,
    output logic [31:0] pack_cnt,
    output logic [31:0] err_cnt
);

    localparam int DATA_WORDS = SCS_NUM / 4;
    localparam int CNT_W      = BIT_WIDTH(DATA_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WORDS - 1);
    localparam logic [1:0]       LAST_HDR = 2'(HDR_WORDS - 1);

    state_t           state_q, state_d;
    logic [1:0]       hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pad_q, pad_d;
    logic [2:0]       ante_q, ante_d;
    logic [15:0]      frame_q, frame_d;
    logic [7:0]       slot_q, slot_d;
    logic [7:0]       symbol_q, symbol_d;
    logic [63:0]      data_q, data_d;
    logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, error_q, error_d;
    logic [63:0]      hdr_word;
    logic             adv, ready, err_inc;

    assign adv = !valid_q || dout_ready;

    ul_pack_hdr_gen #(.DST_MAC(DST_MAC), .SRC_MAC(SRC_MAC), .ETH_TYPE(ETH_TYPE)) u_hdr_gen (
        .idx_i    (hdr_idx_q),
        .ante_i   (ante_q),
        .frame_i  (frame_q),
        .slot_i   (slot_q),
        .symbol_i (symbol_q),
        .word_o   (hdr_word)
    );

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        cnt_d     = cnt_q;
        pad_d     = pad_q;
        ante_d    = ante_q;
        frame_d   = frame_q;
        slot_d    = slot_q;
        symbol_d  = symbol_q;
        data_d    = data_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        error_d   = error_q;
        ready     = 1'b0;
        err_inc   = 1'b0;
        if (adv) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            error_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                ready = !(din_valid && din_sop);
                if (din_valid && din_sop) begin
                    ante_d    = din_ante;
                    frame_d   = din_frame;
                    slot_d    = din_slot;
                    symbol_d  = din_symbol;
                    cnt_d     = '0;
                    pad_d     = 1'b0;
                    hdr_idx_d = 2'd0;
                    state_d   = HDR;
                    // Word 0 is constant, so it goes out now to keep packets back-to-back
                    if (adv) begin
                        data_d    = hdr_word;
                        valid_d   = 1'b1;
                        sop_d     = 1'b1;
                        hdr_idx_d = 2'd1;
                    end
                end else if (din_valid) begin
                    err_inc = 1'b1;
                end
            end
            HDR: begin
                if (adv) begin
                    data_d  = hdr_word;
                    valid_d = 1'b1;
                    sop_d   = (hdr_idx_q == 2'd0);
                    if (hdr_idx_q == LAST_HDR) begin
                        hdr_idx_d = 2'd0;
                        state_d   = DATA;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (pad_q) begin
                    if (adv) begin
                        data_d  = '0;
                        valid_d = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            eop_d   = 1'b1;
                            error_d = 1'b1;
                            pad_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    ready = adv;
                    if (adv && din_valid) begin
                        data_d  = din_data;
                        valid_d = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            eop_d = 1'b1;
                            if (din_eop) begin
                                state_d = IDLE;
                            end else begin
                                error_d = 1'b1;
                                err_inc = 1'b1;
                                state_d = DROP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            if (din_eop) begin
                                pad_d   = 1'b1;
                                err_inc = 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                ready = 1'b1;
                if (din_valid && din_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_idx_q <= '0;
            cnt_q     <= '0;
            pad_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            cnt_q     <= cnt_d;
            pad_q     <= pad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            error_q   <= error_d;
        end
    end

    // Captured header fields are only read after a new sop loads them
    always_ff @(posedge clk_in) begin
        ante_q   <= ante_d;
        frame_q  <= frame_d;
        slot_q   <= slot_d;
        symbol_q <= symbol_d;
    end

    assign din_ready  = rst_n & ready;
    assign dout_data  = data_q;
    assign dout_valid = valid_q;
    assign dout_sop   = sop_q;
    assign dout_eop   = eop_q;
    assign dout_error = error_q;
    assign dout_empty = 3'd0;

`ifdef UL_PACK_STATS_EN
    logic [31:0] pack_cnt_q, err_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (valid_q && dout_ready && eop_q) begin
                pack_cnt_q <= pack_cnt_q + 32'd1;
            end
            if (err_inc) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign pack_cnt = pack_cnt_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = err_inc;
    assign pack_cnt     = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: doc/ul_pack.md
UL_PACK -- requirements
Module: ul_pack

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk_in and rst_n.
REQ-002 Parameter SCS_NUM SHALL default to 3276; it is the number of subcarriers per symbol per antenna, and there are DATA_WORDS = SCS_NUM/4 64-bit IQ words per antenna.
REQ-003 Parameter DST_MAC SHALL default to 48'hFFFF_FFFF_FFFF and is the destination MAC placed in the header.
REQ-004 Parameter SRC_MAC SHALL default to 48'h0000_0000_0001 and is the source MAC placed in the header.
REQ-005 Parameter ETH_TYPE SHALL default to 16'hAEFE and is the EtherType placed in the header.
REQ-006 The ports SHALL be, clock and reset first:
- clk_in  in  1  clock
- rst_n  in  1  async active-low reset
- din_valid  in  1  antenna IQ word valid
- din_sop  in  1  first IQ word of an antenna symbol
- din_eop  in  1  last IQ word of an antenna symbol
- din_data  in  64  IQ word (4 subcarriers)
- din_ante  in  3  antenna index
- din_frame  in  16  frame index
- din_slot  in  8  slot index
- din_symbol  in  8  symbol index
- din_ready  out  1  input accepted when high with din_valid
- dout_data  out  64  Avalon-ST data to MAC, big endian
- dout_valid  out  1  data valid
- dout_sop  out  1  start of packet
- dout_eop  out  1  end of packet
- dout_empty  out  3  empty bytes, always 0
- dout_error  out  1  packet error, qualified by dout_eop
- dout_ready  in  1  MAC ready
- pack_cnt  out  32  packets sent
- err_cnt  out  32  length or framing errors

Function
REQ-007 One Ethernet packet SHALL be produced per antenna symbol: 3 header words followed by DATA_WORDS data words; dout_sop SHALL be on header word 0 and dout_eop on the last data word.
REQ-008 Header word 0 SHALL be {DST_MAC, SRC_MAC[47:32]}.
REQ-009 Header word 1 SHALL be {SRC_MAC[31:0], ETH_TYPE, 13'h0, ante}.
REQ-010 Header word 2 SHALL be {frame, slot, symbol, 32'h0}.
REQ-011 The FSM SHALL have the states IDLE, HDR, DATA and DROP.
REQ-012 In IDLE, din_ready=0 only when din_valid and din_sop are both high; the word is not consumed, ante/frame/slot/symbol are captured, and the FSM moves to HDR.
REQ-013 In IDLE, din_valid without din_sop SHALL be consumed (din_ready=1), discarded, and increment err_cnt.
REQ-014 HDR SHALL emit 3 header words with din_ready=0, then go to DATA.
REQ-015 In DATA, din_ready SHALL equal adv, where adv = !dout_valid || dout_ready; each accepted word SHALL appear on dout_data on the next cycle.
REQ-016 The data word counter SHALL count 0..DATA_WORDS-1 with width BIT_WIDTH(DATA_WORDS) and SHALL clear on every transition to HDR.
REQ-017 If din_eop arrives before count DATA_WORDS-1, the remaining words SHALL be zero-padded (din_ready=0), dout_error=1 on eop, and err_cnt SHALL increment.
REQ-018 If count DATA_WORDS-1 is accepted without din_eop, the block SHALL output eop with dout_error=1, increment err_cnt, and go to DROP.
REQ-019 DROP SHALL consume with din_ready=1 until din_eop, then go to IDLE.
REQ-020 din_sop in DATA other than on the first word SHALL be treated as data; no re-sync is performed.
REQ-021 Output registers SHALL update only when adv is high; when dout_ready=0 they SHALL hold all dout_* unchanged.
REQ-022 pack_cnt SHALL increment on every accepted eop (dout_valid & dout_ready & dout_eop); both counters SHALL wrap at 2^32.
REQ-023 Throughput SHALL be 1 word/cycle with no idle cycle between packets when the input is back-to-back.

Reset
REQ-024 On rst_n low, the FSM SHALL go to IDLE, all dout_* and din_ready SHALL be 0, and the counters SHALL be 0; reset mid-packet SHALL abandon the packet with no eop emitted.

Configuration
REQ-025 With UL_PACK_STATS_EN defined, pack_cnt and err_cnt SHALL count as specified; without it, both SHALL be tied to 0 with no counter logic.

Structure
REQ-026 Package ul_pack_pkg SHALL hold the state enum, the HDR_WORDS=3 constant, the header field offsets and the BIT_WIDTH function.
REQ-027 Sub-module ul_pack_hdr_gen SHALL be a combinational header-word mux (index 0..2 to 64-bit word); no other sub-modules.

Verification
REQ-028 With SCS_NUM=16 and one clean symbol (ante=5, frame=16'h0102, slot=3, symbol=7), the bench SHALL see 7 words, word 2 = 64'h0102_0307_0000_0000, error=0, and pack_cnt=1.
REQ-029 With dout_ready toggling 1-0 each cycle, the output sequence SHALL be identical to the clean case and held data SHALL be stable while dout_ready=0.
REQ-030 With din_eop on the 2nd of 4 words, the bench SHALL see 2 zero pad words, dout_error=1 on eop, and err_cnt=1.
REQ-031 With 6 input words and eop on the 6th, the bench SHALL see eop after the 4th with error, words 5-6 dropped, err_cnt=1, and the next symbol clean.
REQ-032 With 3 words without sop in IDLE, they SHALL be discarded, err_cnt=3 and no output.
REQ-033 With rst_n asserted during DATA, the next cycle SHALL show dout_valid=0 and IDLE, and a following clean symbol SHALL pass.
